// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table,
// the blank glyph and the counter width helper.
package sevenseg_pkg;

    // Active-high glyphs, bit 0 = segment a .. bit 6 = segment g.
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/sevenseg_hexdec.sv
// Combinational nibble to active-high seven-segment glyph. No polarity
// handling here; the output registers of the scan driver apply it.
module sevenseg_hexdec
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_HEX[nibble_i];

endmodule

// File: rtl/sevenseg_mux.sv
// Time-multiplexed N-digit hex display driver with dead-time blanking,
// leading-zero blanking and frame-boundary (tear-free) value updates.
module sevenseg_mux
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int COM_ANODE        = 1,
    parameter int DIGIT_ACTIVE_LOW = 1,
    parameter int REFRESH_DIV      = 12000,
    parameter int BLANK_CYCLES     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    lzb_en,
    output logic [6:0]              segout,
    output logic                    dpout,
    output logic [NUM_DIGITS-1:0]   digsel,
    output logic                    frame_done
);

    localparam int CW = cnt_width(REFRESH_DIV);
    localparam int IW = cnt_width(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0]         PRESC_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]         BLANK_END  = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_POL    = (COM_ANODE != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_POL     = (COM_ANODE != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_POL    = {NUM_DIGITS{DIGIT_ACTIVE_LOW != 0}};

    logic [CW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_v_q, pend_v_d;
    logic [VW-1:0]         disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  fd_q, fd_d;

    logic                  tc;
    logic                  wrap;
    logic [3:0]            cur_nib;
    logic [6:0]            hex_seg;
    logic [NUM_DIGITS-1:0] lz;
    logic                  lz_blank;

    sevenseg_hexdec u_hexdec (
        .nibble_i (cur_nib),
        .seg_o    (hex_seg)
    );

    // Scan timing and pending/display update.
    always_comb begin
        tc         = (presc_q == PRESC_LAST);
        wrap       = tc && (idx_q == IDX_LAST);
        presc_d    = tc ? '0 : presc_q + 1'b1;
        idx_d      = idx_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_v_d   = pend_v_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;

        if (tc) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        if (wrap) begin
            pend_v_d = 1'b0;
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp;
            end else if (pend_v_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
        end else if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp;
            pend_v_d   = 1'b1;
        end
    end

    // lz[i] is set when nibbles i..NUM_DIGITS-1 of the display value are all zero.
    always_comb begin
        cur_nib            = disp_val_q[4*idx_q +: 4];
        lz                 = '0;
        lz[NUM_DIGITS-1]   = (disp_val_q[VW-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lz[i] = lz[i+1] && (disp_val_q[4*i +: 4] == 4'h0);
        end
        lz_blank = lzb_en && (idx_q != '0) && lz[idx_q];

        seg_d = SEG_POL ^ SEG_OFF;
        dp_d  = DP_POL;
        dig_d = DIG_POL;
        if (presc_q >= BLANK_END) begin
            seg_d = SEG_POL ^ (lz_blank ? SEG_OFF : hex_seg);
            dp_d  = DP_POL ^ disp_dp_q[idx_q];
            dig_d = DIG_POL ^ (NUM_DIGITS'(1) << idx_q);
        end
        fd_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_v_q   <= 1'b0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            seg_q      <= SEG_POL ^ SEG_OFF;
            dp_q       <= DP_POL;
            dig_q      <= DIG_POL;
            fd_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_v_q   <= pend_v_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            dig_q      <= dig_d;
            fd_q       <= fd_d;
        end
    end

    assign segout     = seg_q;
    assign dpout      = dp_q;
    assign digsel     = dig_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Scoreboarded bench: a cycle-count based reference model pushes the expected
// active-high outputs each clock; a monitor compares both polarity variants.
module tb_sevenseg_mux;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int B     = 1;
    localparam int FRAME = N * R;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   value;
    logic [3:0]    dp;
    logic          load;
    logic          lzb_en;

    logic [6:0]    seg_ca, seg_cc;
    logic          dp_ca, dp_cc;
    logic [3:0]    dig_ca, dig_cc;
    logic          fd_ca, fd_cc;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] dig;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    int          mk;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_ddp, m_pdp;
    logic        m_pv;

    always #5 clk = ~clk;

    sevenseg_mux #(
        .NUM_DIGITS(N), .COM_ANODE(1), .DIGIT_ACTIVE_LOW(1),
        .REFRESH_DIV(R), .BLANK_CYCLES(B)
    ) u_ca (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
        .lzb_en(lzb_en), .segout(seg_ca), .dpout(dp_ca),
        .digsel(dig_ca), .frame_done(fd_ca)
    );

    sevenseg_mux #(
        .NUM_DIGITS(N), .COM_ANODE(0), .DIGIT_ACTIVE_LOW(0),
        .REFRESH_DIV(R), .BLANK_CYCLES(B)
    ) u_cc (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
        .lzb_en(lzb_en), .segout(seg_cc), .dpout(dp_cc),
        .digsel(dig_cc), .frame_done(fd_cc)
    );

    function automatic logic [6:0] hex_ref(input int n);
        case (n)
            0:  return 7'b0111111;
            1:  return 7'b0000110;
            2:  return 7'b1011011;
            3:  return 7'b1001111;
            4:  return 7'b1100110;
            5:  return 7'b1101101;
            6:  return 7'b1111101;
            7:  return 7'b0000111;
            8:  return 7'b1111111;
            9:  return 7'b1100111;
            10: return 7'b1110111;
            11: return 7'b1111100;
            12: return 7'b0111001;
            13: return 7'b1011110;
            14: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: slot and digit follow from the cycle count since reset.
    initial begin
        exp_t e;
        int   ph, d;
        mk = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pv = 1'b0;
        forever begin
            @(posedge clk);
            e = '0;
            if (rst) begin
                mk = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pv = 1'b0;
            end else begin
                ph = mk % R;
                d  = (mk / R) % N;
                if (ph >= B) begin
                    e.dig = 4'(1 << d);
                    e.dp  = m_ddp[d];
                    if (lzb_en && d >= 1 && (m_disp >> (4 * d)) == 16'h0)
                        e.seg = 7'h00;
                    else
                        e.seg = hex_ref(int'((m_disp >> (4 * d)) & 16'hF));
                end
                e.fd = ((mk % FRAME) == FRAME - 1);
                if (e.fd) begin
                    if (load) begin
                        m_disp = value; m_ddp = dp;
                    end else if (m_pv) begin
                        m_disp = m_pend; m_ddp = m_pdp;
                    end
                    m_pv = 1'b0;
                end else if (load) begin
                    m_pend = value; m_pdp = dp; m_pv = 1'b1;
                end
                mk++;
            end
            sb.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ca_seg", {1'b0, seg_ca}, {1'b0, ~e.seg});
                chk("ca_dp",  {7'b0, dp_ca},  {7'b0, ~e.dp});
                chk("ca_dig", {4'b0, dig_ca}, {4'b0, ~e.dig});
                chk("ca_fd",  {7'b0, fd_ca},  {7'b0, e.fd});
                chk("cc_seg", {1'b0, seg_cc}, {1'b0, e.seg});
                chk("cc_dp",  {7'b0, dp_cc},  {7'b0, e.dp});
                chk("cc_dig", {4'b0, dig_cc}, {4'b0, e.dig});
                chk("cc_fd",  {7'b0, fd_cc},  {7'b0, e.fd});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp = d; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while ((mk % FRAME) != p && n < 2 * FRAME) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if ((mk % FRAME) != p) begin
            failures++;
            $display("FAIL wait_phase: got=%0d expected=%0d", mk % FRAME, p);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp = '0; lzb_en = 1'b0;
        step(3);
        rst = 1'b0;

        do_load(16'h1234, 4'b0000);
        step(2 * FRAME + 8);

        wait_phase(5);
        do_load(16'hABCD, 4'b0101);
        step(3);
        do_load(16'h00F0, 4'b0010);
        step(FRAME + 4);

        wait_phase(FRAME - 1);
        do_load(16'h5A5A, 4'b1001);
        step(FRAME + 4);

        lzb_en = 1'b1;
        do_load(16'h0070, 4'b0000);
        step(2 * FRAME);
        do_load(16'h0000, 4'b0000);
        step(2 * FRAME);
        do_load(16'h0000, 4'b1000);
        step(2 * FRAME);

        wait_phase(6);
        do_load(16'h9876, 4'b1111);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2 * FRAME + 4);

        for (int c = 0; c < 600; c++) begin
            load  = ($urandom_range(0, 5) == 0);
            value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp    = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lzb_en = 1'($urandom);
            rst   = ($urandom_range(0, 199) == 0);
            step(1);
        end
        load = 1'b0; rst = 1'b0;
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sevenseg_mux.md
Name: sevenseg_mux

Overview:
- Parametrised multi-digit, time-multiplexed hex driver for seven-segment display banks.
- Holds an N-digit hex value and a per-digit decimal-point mask. Scans the digits at a programmable rate, with dead-time blanking between digits to stop ghosting.
- Updates are tear-free: a new value is applied only at a frame boundary.
- Sits between the application logic and the board pins. Replaces per-digit static decoders.

Parameters:
- NUM_DIGITS, 4: number of digits; must be ≥1.
- COM_ANODE, 1: 1 drives segment and dp outputs active-low; 0 drives them active-high.
- DIGIT_ACTIVE_LOW, 1: 1 drives digit enables active-low; 0 drives them active-high.
- REFRESH_DIV, 12000: clk cycles per digit slot; must be ≥2.
- BLANK_CYCLES, 2: dead-time cycles at the start of each slot; must be < REFRESH_DIV.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous reset, active-high.
- value, in, 4*NUM_DIGITS: hex nibbles; digit i = value[4i+3:4i]; digit 0 is least significant.
- dp, in, NUM_DIGITS: decimal-point mask; bit i belongs to digit i.
- load, in, 1: one-cycle strobe that captures value and dp.
- lzb_en, in, 1: leading-zero blanking enable; level input, sampled live.
- segout, out, 7: segments, bit 0 = a through bit 6 = g; polarity set by COM_ANODE.
- dpout, out, 1: decimal point; polarity set by COM_ANODE.
- digsel, out, NUM_DIGITS: one-hot digit enable; polarity set by DIGIT_ACTIVE_LOW.
- frame_done, out, 1: one-cycle pulse at each frame wrap.

Behaviour:
- Reset values:
  - Prescaler, digit index, pending regs, display regs and the pending-valid flag all clear to 0.
  - segout and dpout are inactive: all 1 if COM_ANODE=1, else all 0.
  - digsel is all inactive.
  - frame_done = 0.
  - Reset mid-scan aborts the scan immediately; an uncommitted load is discarded.
- Prescaler: counts 0 to REFRESH_DIV-1 each slot.
  - At the terminal count it returns to 0 and the digit index advances.
  - The index wraps from NUM_DIGITS-1 to 0.
- Frame wrap: the cycle in which the terminal count occurs and the index is NUM_DIGITS-1.
  - frame_done is asserted on the following cycle, for exactly one cycle.
  - With NUM_DIGITS=1, every slot end is a frame wrap.
- Load and commit:
  - load stores value/dp into the pending regs and sets pending-valid. A later load before the next wrap overwrites the pending regs (last load wins).
  - On a frame wrap with pending-valid set, the pending regs are copied into the display regs and pending-valid clears.
  - If load and a frame wrap coincide, the display regs take the live value/dp inputs directly and pending-valid stays clear.
- Dead time: while prescaler < BLANK_CYCLES, digsel, segout and dpout are all inactive.
- Active portion of a slot:
  - digsel asserts only the bit for the current index.
  - segout shows the decode of the current display nibble.
  - dpout shows the current display dp bit.
- Hex patterns, active-high, g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1100111, A=1110111, B=1111100, C=0111001, D=1011110, E=1111001, F=1110001
- Leading-zero blanking:
  - With lzb_en=1, digit i (i≥1) shows segments off when display nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - dpout is unaffected by blanking.
- Latency: segout, dpout and digsel are registered, one cycle after the prescaler/index state that selects them.
- No outputs glitch; no combinational path runs from any input to any output.

Decomposition:
- Package sevenseg_pkg holds:
  - the SEG_HEX[0:15] 7-bit pattern constant;
  - the SEG_OFF constant;
  - a localparam helper for counter width, $clog2(REFRESH_DIV).
- Sub-module sevenseg_hexdec: combinational nibble → active-high 7-bit pattern. It has no polarity handling; polarity is applied only at the sevenseg_mux output registers.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, COM_ANODE=1, DIGIT_ACTIVE_LOW=1 unless stated):
- Reset and first commit:
  - Hold rst for 3 cycles → segout=7'h7F, dpout=1, digsel=4'hF, frame_done=0.
  - Release rst, then load value=16'h1234, dp=0 → 1234 is committed at the first wrap.
- Scan sequence, after commit:
  - digsel follows 1111 (blank) → 1110 for 3 cycles, showing seg=~0x66 ("4").
  - Then 1101 shows "3", 1011 shows "2", 0111 shows "1".
  - frame_done pulses once every 16 cycles.
- Tear-free update:
  - load 16'hABCD mid-frame, then load 16'h00F0 before the wrap → display stays 1234 until the wrap, then shows 00F0.
  - ABCD is never displayed.
- Coincident load and wrap: load 16'h5A5A on the wrap cycle → the next frame shows 5A5A.
- Leading-zero blanking:
  - With lzb_en=1, value 16'h0070 → digits 3 and 2 blanked, digit 1 shows "7", digit 0 shows "0".
  - With lzb_en=1, value 0 → only digit 0 is lit.
  - With lzb_en=1, dp=4'b1000 → digit 3 shows the dp only.
- Polarity and reset mid-scan:
  - COM_ANODE=0, DIGIT_ACTIVE_LOW=0 → all outputs are inverted relative to the above.
  - Assert rst mid-slot → outputs go inactive on the next cycle and the pending load is discarded.
